popcount_accum: RTL



---
 rtl/popcount_accum_pkg.sv | 21 ++
 rtl/popcount_accum_if.sv | 27 ++
 rtl/popcount_accum_ones_count.sv | 16 +
 rtl/popcount_accum.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/popcount_accum_pkg.sv
// Shared types and width helpers for the frame-level ones accumulator.
package popcount_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int acc_w(input int data_w, input int frame_len);
    return $clog2(data_w * frame_len + 1);
  endfunction

  function automatic int wrd_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/popcount_accum_if.sv
// Word-in / frame-result stream bundle for popcount_accum.
interface popcount_accum_if import popcount_pkg::*; #(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 16
) ();
  localparam int ACC_W = acc_w(DATA_W, FRAME_LEN);
  localparam int WRD_W = wrd_w(FRAME_LEN);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [WRD_W-1:0]  out_words;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_sum, out_words, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_sum, out_words, out_valid
  );
endinterface

// File: rtl/popcount_accum_ones_count.sv
// Combinational population count of one input word.
module ones_count #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 4
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);
  // Sum of the individual bits of the word.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end
endmodule

// File: rtl/popcount_accum.sv
// Frame ones accumulator: sums per-word popcounts until in_last or FRAME_LEN words.
// Optional build macro POPCOUNT_ACCUM_PIPE_EN inserts a stage between popcount and adder.
module popcount_accum import popcount_pkg::*; #(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 16
) (
  input logic             clk,
  input logic             rst,
  popcount_accum_if.slave bus
);
  localparam int CNT_W = cnt_w(DATA_W);
  localparam int ACC_W = acc_w(DATA_W, FRAME_LEN);
  localparam int WRD_W = wrd_w(FRAME_LEN);
  localparam logic [WRD_W-1:0] LAST_IDX = WRD_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_s;
  logic             close_s;
  state_e           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_r;
  logic [WRD_W-1:0] wcnt_r;
  logic [WRD_W-1:0] words_r;
  logic             valid_r;

  ones_count #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ones (
    .data  (bus.in_data),
    .count (cnt_s)
  );

  // A word closes its frame on in_last or when it fills the frame; both at once is one close.
  assign close_s       = bus.in_last || (wcnt_r == LAST_IDX);
  assign bus.out_sum   = sum_r;
  assign bus.out_words = words_r;
  assign bus.out_valid = valid_r;

`ifdef POPCOUNT_ACCUM_PIPE_EN
  logic [CNT_W-1:0] pcnt_r;
  logic [WRD_W-1:0] pwords_r;
  logic             plast_r;
  logic             pvalid_r;
  logic             closing_r;

  // closing_r stops intake once a closing word sits in the stage, until the result is taken.
  assign bus.in_ready = !rst && (state_r == ACCUM) && !closing_r;

  // Front half: word counting and the popcount stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r    <= '0;
      pwords_r  <= '0;
      plast_r   <= 1'b0;
      pvalid_r  <= 1'b0;
      closing_r <= 1'b0;
      wcnt_r    <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      pvalid_r <= 1'b1;
      pcnt_r   <= cnt_s;
      plast_r  <= close_s;
      pwords_r <= wcnt_r + WRD_W'(1);
      if (close_s) begin
        wcnt_r    <= '0;
        closing_r <= 1'b1;
      end else begin
        wcnt_r <= wcnt_r + WRD_W'(1);
      end
    end else begin
      pvalid_r <= 1'b0;
      if ((state_r == HOLD) && bus.out_ready) begin
        closing_r <= 1'b0;
      end
    end
  end

  // Back half: accumulator, result registers and frame FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
      acc_r   <= '0;
      sum_r   <= '0;
      words_r <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (pvalid_r) begin
            if (plast_r) begin
              sum_r   <= acc_r + ACC_W'(pcnt_r);
              words_r <= pwords_r;
              acc_r   <= '0;
              valid_r <= 1'b1;
              state_r <= HOLD;
            end else begin
              acc_r <= acc_r + ACC_W'(pcnt_r);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            state_r <= ACCUM;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ACCUM;
        end
      endcase
    end
  end
`else
  assign bus.in_ready = !rst && (state_r == ACCUM);

  // Frame FSM with accumulator and result registers in one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
      acc_r   <= '0;
      wcnt_r  <= '0;
      sum_r   <= '0;
      words_r <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (bus.in_valid) begin
            if (close_s) begin
              sum_r   <= acc_r + ACC_W'(cnt_s);
              words_r <= wcnt_r + WRD_W'(1);
              acc_r   <= '0;
              wcnt_r  <= '0;
              valid_r <= 1'b1;
              state_r <= HOLD;
            end else begin
              acc_r  <= acc_r + ACC_W'(cnt_s);
              wcnt_r <= wcnt_r + WRD_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            state_r <= ACCUM;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ACCUM;
        end
      endcase
    end
  end
`endif
endmodule
